mem_write_monitor: RTL
======================

Name: mem_write_monitor

Overview:
- Parametrised, synthesizable successor to the single-entry end-of-program memory-write check used in the CPU benches.
- Sits beside `top`, snooping the data-memory write port (mem_write / data_addr / write_data).
- Compares writes against a programmable, ordered table of up to DEPTH expected (addr, data) pairs, tolerating one scratch address.
- Reports pass/fail, a failure code, match progress and a cycle count; bounded by a timeout.

Parameters:
- WIDTH, 32, data/address width
- DEPTH, 4, max expected-write entries
- TIMEOUT, 1000, max RUN cycles before timeout failure (>=1)
- CW, 32, cycle_count width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- exp_we  in  1  load strobe for next table entry (IDLE only)
- exp_addr  in  WIDTH  expected address for loaded entry
- exp_data  in  WIDTH  expected data for loaded entry
- ignore_addr  in  WIDTH  scratch address whose non-matching writes are tolerated; sampled every RUN cycle
- start  in  1  IDLE->RUN
- mem_write  in  1  snooped write enable
- data_addr  in  WIDTH  snooped address
- write_data  in  WIDTH  snooped data
- load_full  out  1  table holds DEPTH entries
- done  out  1  in PASS or FAIL
- pass  out  1  in PASS
- fail  out  1  in FAIL
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout
- match_count  out  $clog2(DEPTH+1)  entries matched so far
- cycle_count  out  CW  RUN cycles elapsed, frozen in PASS/FAIL

Behaviour:
- Reset: state IDLE; entry count, match_count, cycle_count, fail_code = 0; done/pass/fail = 0; load_full = 0. Table storage is not cleared.
- Reset mid-operation: returns to IDLE in any state; load count is lost.
- States: IDLE, RUN, PASS, FAIL. PASS and FAIL are terminal until reset.
- IDLE, exp_we=1, start=0, count<DEPTH: write entry[count], count++.
- IDLE, exp_we=1 with count==DEPTH: ignored, no error.
- IDLE, exp_we and start together: start wins, load ignored.
- IDLE, start=1: RUN next cycle. mem_write in IDLE is ignored.
- RUN: cycle_count increments every RUN cycle (saturates at all-ones). Let E = entry[match_count]. When mem_write=1, first matching rule applies:
  - data_addr==E.addr and write_data==E.data -> match_count++
  - else data_addr==ignore_addr -> no action
  - else data_addr==E.addr -> FAIL, code 2
  - else -> FAIL, code 1
- RUN, completion: when match_count reaches count, enter PASS next cycle. The decision is registered; outputs update the cycle after the deciding edge.
- RUN, count==0: PASS one cycle after entering RUN.
- Timeout: if cycle_count==TIMEOUT-1 and no completion that cycle -> FAIL, code 3.
- Completing match and timeout on the same cycle: PASS wins.
- Checks in RUN are strictly ordered: a write matching a later entry but not E is a failure.

Optional Feature:
- MEMMON_STOP_EN defined: on entering PASS, prints "Simulation succeeded"; on entering FAIL, prints "Simulation failed code=<n> addr=<hex> data=<hex>". Either case then calls $stop. Sim-only code inside the ifdef.
- Undefined: no system tasks; flags only, fully synthesizable.

Test Plan:
- Load (100,25), ignore_addr=96, start; writes 96/7, 96/3, 100/25 -> pass=1, fail_code=0, match_count=1, one cycle after the 100 write.
- Load (100,25), start; write 100/24 -> fail=1, fail_code=2, match_count=0.
- Load (100,25), ignore_addr=96, start; write 104/25 -> fail=1, fail_code=1.
- TIMEOUT=16; load (100,25), start, no writes -> fail_code=3, cycle_count=16 frozen.
- Load (100,25),(104,9); writes 104/9 then 100/25 -> fail_code=1 on first write. Correct order instead -> pass, match_count=2. Fifth load with DEPTH=4 -> ignored, load_full=1.
- Reset asserted mid-RUN after 1 match -> IDLE, all outputs 0. Start with no loads -> pass one cycle after RUN entry.

Source files
------------

// File: rtl/mem_write_monitor.sv
// Snoops data-memory writes and checks them, in order, against a loaded table of expected
// (addr, data) pairs. Define MEMMON_STOP_EN to print the verdict and $stop in simulation.
module mem_write_monitor #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned CW      = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       exp_we,
   input  logic [WIDTH-1:0]           exp_addr,
   input  logic [WIDTH-1:0]           exp_data,
   input  logic [WIDTH-1:0]           ignore_addr,
   input  logic                       start,
   input  logic                       mem_write,
   input  logic [WIDTH-1:0]           data_addr,
   input  logic [WIDTH-1:0]           write_data,
   output logic                       load_full,
   output logic                       done,
   output logic                       pass,
   output logic                       fail,
   output logic [1:0]                 fail_code,
   output logic [$clog2(DEPTH+1)-1:0] match_count,
   output logic [CW-1:0]              cycle_count
);

   localparam int unsigned MW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

   state_e           state_q, state_d;
   logic [MW-1:0]    count_q, count_d;
   logic [MW-1:0]    match_q, match_d;
   logic [CW-1:0]    cycle_q, cycle_d;
   logic [1:0]       code_q, code_d;
   logic             tab_we;
   logic [WIDTH-1:0] tab_addr [DEPTH];
   logic [WIDTH-1:0] tab_data [DEPTH];
   logic [IW-1:0]    load_idx, match_idx;
   logic [WIDTH-1:0] e_addr, e_data;
   logic             hit;

   assign load_idx  = count_q[IW-1:0];
   assign match_idx = match_q[IW-1:0];
   assign e_addr    = tab_addr[match_idx];
   assign e_data    = tab_data[match_idx];
   assign hit       = mem_write && (data_addr == e_addr) && (write_data == e_data);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      match_d = match_q;
      cycle_d = cycle_q;
      code_d  = code_q;
      tab_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end else if (exp_we && (count_q < MW'(DEPTH))) begin
               tab_we  = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
         StRun: begin
            if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
            // Table already exhausted (including the empty table): nothing left to check.
            if (match_q == count_q) begin
               state_d = StPass;
            end else if (hit) begin
               match_d = match_q + 1'b1;
               if (match_d == count_q) state_d = StPass;
            end else if (mem_write && (data_addr != ignore_addr)) begin
               state_d = StFail;
               code_d  = (data_addr == e_addr) ? 2'd2 : 2'd1;
            end
            // Completion on the last allowed cycle takes priority over the timeout.
            if ((state_d == StRun) && (cycle_q == CW'(TIMEOUT - 1))) begin
               state_d = StFail;
               code_d  = 2'd3;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         match_q <= '0;
         cycle_q <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         match_q <= match_d;
         cycle_q <= cycle_d;
         code_q  <= code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tab_we) begin
         tab_addr[load_idx] <= exp_addr;
         tab_data[load_idx] <= exp_data;
      end
   end

   assign load_full   = (count_q == MW'(DEPTH));
   assign pass        = (state_q == StPass);
   assign fail        = (state_q == StFail);
   assign done        = pass || fail;
   assign fail_code   = code_q;
   assign match_count = match_q;
   assign cycle_count = cycle_q;

`ifdef MEMMON_STOP_EN
   always @(posedge clk) begin
      if (!reset && (state_q == StRun) && (state_d == StPass)) begin
         $display("Simulation succeeded");
         $stop;
      end else if (!reset && (state_q == StRun) && (state_d == StFail)) begin
         $display("Simulation failed code=%0d addr=%h data=%h", code_d, data_addr, write_data);
         $stop;
      end
   end
`else
   // Flags only; no simulation side effects.
`endif

endmodule
